uart_sample_sched: RTL and testbench

Frames and schedules calibrated CODEC samples onto the shared `uart_tx` byte transmitter. On each rising edge of `sample_clk` it snapshots up to four channels. It then sends one 5-byte frame ("C", "H", channel id, MSB, LSB) per enabled channel, in round-robin order. It sits between the calibration block outputs and `uart_tx`, and owns the `tx_start`/`tx_data` handshake.

---
 rtl/uart_sample_sched.sv | 215 +++++++++++++++++++++
 tb/tb_uart_sample_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_sample_sched.sv
// rtl/uart_sample_sched.sv - snapshots up to four CODEC channels and frames them onto uart_tx.
// Optional trailing XOR checksum byte: UART_SCHED_CHECKSUM_EN.
module uart_sample_sched #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sample_clk,
    input  logic [W-1:0] sample_in0,
    input  logic [W-1:0] sample_in1,
    input  logic [W-1:0] sample_in2,
    input  logic [W-1:0] sample_in3,
    input  logic [3:0]   ch_mask,
    output logic         tx_start,
    output logic [7:0]   tx_data,
    input  logic         tx_busy,
    output logic         frame_done,
    output logic [7:0]   drop_cnt,
    output logic         led_frame
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC0,
        S_SYNC1,
        S_CHID,
        S_MSB,
        S_LSB,
`ifdef UART_SCHED_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_ACK,
        PH_DRAIN
    } phase_e;

    state_e         state_q, state_d;
    phase_e         phase_q, phase_d;
    logic           sclk_q, sclk_d;
    logic [3:0]     pending_q, pending_d;
    logic [1:0]     rr_ptr_q, rr_ptr_d;
    logic [1:0]     cur_ch_q, cur_ch_d;
    logic [W-1:0]   snap0_q, snap0_d;
    logic [W-1:0]   snap1_q, snap1_d;
    logic [W-1:0]   snap2_q, snap2_d;
    logic [W-1:0]   snap3_q, snap3_d;
    logic [7:0]     drop_cnt_q, drop_cnt_d;
    logic           led_q, led_d;

    logic           snap_ev;
    logic [W-1:0]   snap_c;
    logic [7:0]     chid_byte;
    logic [7:0]     cur_byte;
    logic [3:0]     pend_clr;
    logic [1:0]     next_ptr;

    // First set bit of p at or after start, wrapping 3 -> 0.
    function automatic logic [1:0] pick_ch(input logic [3:0] p, input logic [1:0] start);
        logic [1:0] idx;
        logic       found;
        pick_ch = start;
        found   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!found && p[idx]) begin
                pick_ch = idx;
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        sclk_d     = sample_clk;
        pending_d  = pending_q;
        rr_ptr_d   = rr_ptr_q;
        cur_ch_d   = cur_ch_q;
        snap0_d    = snap0_q;
        snap1_d    = snap1_q;
        snap2_d    = snap2_q;
        snap3_d    = snap3_q;
        drop_cnt_d = drop_cnt_q;
        led_d      = led_q;
        tx_start   = 1'b0;
        frame_done = 1'b0;
        pend_clr   = pending_q & ~(4'b0001 << cur_ch_q);
        next_ptr   = cur_ch_q + 2'd1;
        snap_ev    = sample_clk & ~sclk_q;

        case (cur_ch_q)
            2'd0:    snap_c = snap0_q;
            2'd1:    snap_c = snap1_q;
            2'd2:    snap_c = snap2_q;
            default: snap_c = snap3_q;
        endcase
        chid_byte = 8'h30 + {6'b0, cur_ch_q};

        case (state_q)
            S_SYNC0: cur_byte = 8'h43;
            S_SYNC1: cur_byte = 8'h48;
            S_CHID:  cur_byte = chid_byte;
            S_MSB:   cur_byte = snap_c[15:8];
            S_LSB:   cur_byte = snap_c[7:0];
`ifdef UART_SCHED_CHECKSUM_EN
            S_CSUM:  cur_byte = chid_byte ^ snap_c[15:8] ^ snap_c[7:0];
`endif
            default: cur_byte = 8'h00;
        endcase

        // A snapshot is only taken once the previous one has been fully sent.
        if (snap_ev) begin
            if (pending_q != 4'b0000) begin
                if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
            end else if (ch_mask != 4'b0000) begin
                snap0_d   = sample_in0;
                snap1_d   = sample_in1;
                snap2_d   = sample_in2;
                snap3_d   = sample_in3;
                pending_d = ch_mask;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (pending_q != 4'b0000) begin
                    state_d  = S_SYNC0;
                    phase_d  = PH_ISSUE;
                    cur_ch_d = pick_ch(pending_q, rr_ptr_q);
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                led_d      = ~led_q;
                pending_d  = pend_clr;
                rr_ptr_d   = next_ptr;
                phase_d    = PH_ISSUE;
                if (pend_clr != 4'b0000) begin
                    state_d  = S_SYNC0;
                    cur_ch_d = pick_ch(pend_clr, next_ptr);
                end else begin
                    state_d  = S_IDLE;
                end
            end
            default: begin
                case (phase_q)
                    PH_ISSUE: begin
                        if (!tx_busy) begin
                            tx_start = 1'b1;
                            phase_d  = PH_ACK;
                        end
                    end
                    PH_ACK: begin
                        if (tx_busy) phase_d = PH_DRAIN;
                    end
                    default: begin
                        if (!tx_busy) begin
                            phase_d = PH_ISSUE;
                            case (state_q)
                                S_SYNC0: state_d = S_SYNC1;
                                S_SYNC1: state_d = S_CHID;
                                S_CHID:  state_d = S_MSB;
                                S_MSB:   state_d = S_LSB;
`ifdef UART_SCHED_CHECKSUM_EN
                                S_LSB:   state_d = S_CSUM;
`endif
                                default: state_d = S_DONE;
                            endcase
                        end
                    end
                endcase
            end
        endcase

        tx_data = tx_start ? cur_byte : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            phase_q    <= PH_ISSUE;
            sclk_q     <= 1'b0;
            pending_q  <= 4'b0000;
            rr_ptr_q   <= 2'd0;
            cur_ch_q   <= 2'd0;
            snap0_q    <= '0;
            snap1_q    <= '0;
            snap2_q    <= '0;
            snap3_q    <= '0;
            drop_cnt_q <= 8'h00;
            led_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            sclk_q     <= sclk_d;
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            cur_ch_q   <= cur_ch_d;
            snap0_q    <= snap0_d;
            snap1_q    <= snap1_d;
            snap2_q    <= snap2_d;
            snap3_q    <= snap3_d;
            drop_cnt_q <= drop_cnt_d;
            led_q      <= led_d;
        end
    end

    assign drop_cnt  = drop_cnt_q;
    assign led_frame = led_q;

endmodule

// File: tb/tb_uart_sample_sched.sv
// tb/tb_uart_sample_sched.sv - directed checks of uart_sample_sched against an ideal uart_tx model.
module tb_uart_sample_sched;

`ifdef UART_SCHED_CHECKSUM_EN
    localparam int FB = 6;
`else
    localparam int FB = 5;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_clk = 1'b0;
    logic [15:0] sample_in0 = '0, sample_in1 = '0, sample_in2 = '0, sample_in3 = '0;
    logic [3:0]  ch_mask = 4'b0000;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        frame_done;
    logic [7:0]  drop_cnt;
    logic        led_frame;

    logic        force_busy = 1'b0;
    int          busy_cnt = 0;
    logic        start_lat = 1'b0;
    logic        prev_start = 1'b0;
    int          b2b = 0;
    int          fd_cnt = 0;
    logic [7:0]  bytes[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    uart_sample_sched #(.W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_clk (sample_clk),
        .sample_in0 (sample_in0),
        .sample_in1 (sample_in1),
        .sample_in2 (sample_in2),
        .sample_in3 (sample_in3),
        .ch_mask    (ch_mask),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .frame_done (frame_done),
        .drop_cnt   (drop_cnt),
        .led_frame  (led_frame)
    );

    // Ideal uart_tx: busy for 10 cycles starting the cycle after tx_start.
    assign tx_busy = force_busy | (busy_cnt != 0);

    always @(negedge clk) begin
        if (tx_start) begin
            bytes.push_back(tx_data);
            if (prev_start) b2b = b2b + 1;
        end
        if (frame_done) fd_cnt = fd_cnt + 1;
        prev_start = tx_start;
        start_lat  = tx_start;
    end

    always @(posedge clk) begin
        if (start_lat) busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] fbyte(input int ch, input logic [15:0] s, input int i);
        logic [7:0] id;
        id = 8'h30 + 8'(ch);
        case (i)
            0:       fbyte = 8'h43;
            1:       fbyte = 8'h48;
            2:       fbyte = id;
            3:       fbyte = s[15:8];
            4:       fbyte = s[7:0];
            default: fbyte = id ^ s[15:8] ^ s[7:0];
        endcase
    endfunction

    function automatic logic [31:0] byte_at(input int idx);
        if (idx < bytes.size()) byte_at = {24'h0, bytes[idx]};
        else byte_at = 32'hDEAD;
    endfunction

    task automatic check_frame(input string tag, input int base, input int ch, input logic [15:0] s);
        for (int i = 0; i < FB; i++)
            check(tag, byte_at(base + i), {24'h0, fbyte(ch, s, i)});
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic snap_edge(input int hold);
        @(posedge clk); #1 sample_clk = 1'b1;
        repeat (hold) @(posedge clk);
        #1 sample_clk = 1'b0;
    endtask

    task automatic wait_fd(input string tag, input int target, input int budget);
        int t;
        t = 0;
        while (fd_cnt < target && t < budget) begin
            @(posedge clk);
            t = t + 1;
        end
        @(negedge clk);
        check(tag, (fd_cnt >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        int base;
        logic [15:0] s3 [4];

        do_reset();
        @(negedge clk);
        check("rst_tx_start", {31'h0, tx_start}, 0);
        check("rst_tx_data", {24'h0, tx_data}, 0);
        check("rst_frame_done", {31'h0, frame_done}, 0);
        check("rst_drop_cnt", {24'h0, drop_cnt}, 0);
        check("rst_led", {31'h0, led_frame}, 0);

        // Single channel frame plus snapshot-to-first-start latency.
        ch_mask = 4'b0001; sample_in0 = 16'h1234;
        @(posedge clk); #1 sample_clk = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("lat_t1_no_start", {31'h0, tx_start}, 0);
        @(posedge clk);
        @(negedge clk);
        check("lat_t2_start", {31'h0, tx_start}, 1);
        check("lat_t2_data", {24'h0, tx_data}, 32'h43);
        @(posedge clk); #1 sample_clk = 1'b0;
        base = fd_cnt;
        wait_fd("t1_timeout", base + 1, 400);
        check_frame("t1_byte", 0, 0, 16'h1234);
        check("t1_count", bytes.size(), FB);
        check("t1_led", {31'h0, led_frame}, 1);

        // Four channels in round-robin order.
        do_reset();
        bytes.delete();
        ch_mask = 4'b1111;
        sample_in0 = 16'h0001; sample_in1 = 16'h0002; sample_in2 = 16'h0003; sample_in3 = 16'h8000;
        snap_edge(2);
        ch_mask = 4'b0010;
        base = fd_cnt;
        wait_fd("t2_timeout", base + 4, 1200);
        check_frame("t2_ch0", 0 * FB, 0, 16'h0001);
        check_frame("t2_ch1", 1 * FB, 1, 16'h0002);
        check_frame("t2_ch2", 2 * FB, 2, 16'h0003);
        check_frame("t2_ch3", 3 * FB, 3, 16'h8000);
        check("t2_drop", {24'h0, drop_cnt}, 0);
        check("t2_led", {31'h0, led_frame}, 0);

        // Overrun: five edges 20 cycles apart, only the first snapshot is sent.
        do_reset();
        bytes.delete();
        ch_mask = 4'b1111;
        s3[0] = 16'h1111; s3[1] = 16'h2222; s3[2] = 16'h3333; s3[3] = 16'h4444;
        sample_in0 = s3[0]; sample_in1 = s3[1]; sample_in2 = s3[2]; sample_in3 = s3[3];
        base = fd_cnt;
        for (int e = 0; e < 5; e++) begin
            snap_edge(10);
            sample_in0 = 16'hDEAD; sample_in1 = 16'hBEEF; sample_in2 = 16'hCAFE; sample_in3 = 16'hF00D;
            repeat (9) @(posedge clk);
        end
        wait_fd("t3_timeout", base + 4, 1200);
        repeat (40) @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < 4; c++) check_frame("t3_frame", c * FB, c, s3[c]);
        check("t3_count", bytes.size(), 4 * FB);
        check("t3_drop", {24'h0, drop_cnt}, 4);

        // Reset during the MSB byte.
        do_reset();
        bytes.delete();
        ch_mask = 4'b0001; sample_in0 = 16'h1234;
        snap_edge(2);
        for (int t = 0; t < 300 && bytes.size() < 4; t++) @(posedge clk);
        @(negedge clk);
        check("t4_reach_msb", bytes.size(), 4);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("t4_start_after_rst", {31'h0, tx_start}, 0);
        check("t4_drop_after_rst", {24'h0, drop_cnt}, 0);
        repeat (80) @(posedge clk);
        @(negedge clk);
        check("t4_quiet", bytes.size(), 4);
        bytes.delete();
        ch_mask = 4'b0011; sample_in0 = 16'h5678; sample_in1 = 16'h9ABC;
        base = fd_cnt;
        snap_edge(2);
        wait_fd("t4_timeout", base + 2, 800);
        check("t4_first_c", byte_at(0), 32'h43);
        check("t4_first_ch0", byte_at(2), 32'h30);
        check_frame("t4_ch1", FB, 1, 16'h9ABC);

        // Checksum frame for channel 2.
        do_reset();
        bytes.delete();
        ch_mask = 4'b0100; sample_in2 = 16'hA55A;
        base = fd_cnt;
        snap_edge(2);
        wait_fd("t5_timeout", base + 1, 400);
        check("t5_b0", byte_at(0), 32'h43);
        check("t5_b1", byte_at(1), 32'h48);
        check("t5_b2", byte_at(2), 32'h32);
        check("t5_b3", byte_at(3), 32'hA5);
        check("t5_b4", byte_at(4), 32'h5A);
`ifdef UART_SCHED_CHECKSUM_EN
        check("t5_csum", byte_at(5), 32'hCD);
`endif
        check("t5_count", bytes.size(), FB);

        // tx_busy held high: nothing issued until it falls.
        do_reset();
        bytes.delete();
        @(posedge clk); #1 force_busy = 1'b1;
        ch_mask = 4'b0001; sample_in0 = 16'h0F0F;
        base = fd_cnt;
        snap_edge(2);
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("t6_held", bytes.size(), 0);
        @(posedge clk); #1 force_busy = 1'b0;
        @(negedge clk);
        check("t6_release_start", {31'h0, tx_start}, 1);
        wait_fd("t6_timeout", base + 1, 400);
        check_frame("t6_byte", 0, 0, 16'h0F0F);

        check("no_back_to_back", b2b, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
